// File: rtl/stoch_weight_update_pkg.sv
// Shared constants and types for the probabilistic STDP weight-update block.
package stdp_pkg;

  localparam int unsigned      PW           = 7;
  localparam logic [PW-1:0]    LFSR_TAPS    = 7'b1100000;  // x^7 + x^6 + 1
  localparam logic [PW-1:0]    DEFAULT_SEED = 7'h5A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    APPLY = 2'd2
  } swu_state_e;

  // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
  function automatic logic [PW-1:0] fix_seed(input logic [PW-1:0] s);
    return (s == '0) ? {{(PW-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage

// File: rtl/stoch_weight_update_if.sv
// Update-request / result bundle between the spike-timing comparator and the weight block.
interface stoch_weight_update_if #(
  parameter int PW = 7,
  parameter int WW = 3
);
  logic          upd_valid;
  logic [PW-1:0] prob;
  logic          inc;
  logic          upd_ready;
  logic          upd_done;
  logic          applied;
  logic [WW-1:0] weight;

  modport master (
    output upd_valid, prob, inc,
    input  upd_ready, upd_done, applied, weight
  );

  modport slave (
    input  upd_valid, prob, inc,
    output upd_ready, upd_done, applied, weight
  );
endinterface

// File: rtl/stoch_weight_update_lfsr.sv
// Free-running Fibonacci LFSR used as the random source for stochastic updates.
module lfsr_prng
  import stdp_pkg::*;
#(
  parameter int                WIDTH = 7,
  parameter logic [WIDTH-1:0]  SEED  = 7'h5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] TAPS = LFSR_TAPS[WIDTH-1:0];

  logic fb;
  assign fb = ^(q & TAPS);

  always_ff @(posedge clk) begin
    if (rst)     q <= SEED;
    else if (en) q <= {q[WIDTH-2:0], fb};
  end

endmodule

// File: rtl/stoch_weight_update.sv
// Probabilistic STDP step: +/-1 saturating weight change with probability prob/127.
// Optional build macro SWU_DROP_CNT_EN adds a saturating count of dropped strobes.
module stoch_weight_update
  import stdp_pkg::*;
#(
  parameter int            WW     = 3,
  parameter int            W_INIT = 0,
  parameter logic [PW-1:0] SEED   = DEFAULT_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  stoch_weight_update_if.slave       bus
`ifdef SWU_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam logic [PW-1:0] SEED_EFF = fix_seed(SEED);
  localparam logic [WW-1:0] W_MAX    = '1;

  swu_state_e    state_q, state_d;
  logic [PW-1:0] lfsr_q;
  logic [PW-1:0] prob_q;
  logic          inc_q;
  logic [WW-1:0] weight_q;
  logic          applied_q;
  logic          hit, step_en;

  lfsr_prng #(.WIDTH(PW), .SEED(SEED_EFF)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .q   (lfsr_q)
  );

  // The draw is evaluated at the DRAW edge so the registered weight and
  // upd_done become visible together in the APPLY cycle.
  assign hit     = (lfsr_q <= prob_q);
  assign step_en = hit && (inc_q ? (weight_q != W_MAX) : (weight_q != '0));

  always_comb begin
    state_d       = state_q;
    bus.upd_ready = 1'b0;
    bus.upd_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.upd_ready = 1'b1;
        if (bus.upd_valid) state_d = DRAW;
      end
      DRAW:  state_d = APPLY;
      APPLY: begin
        bus.upd_done = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prob_q    <= '0;
      inc_q     <= 1'b0;
      weight_q  <= WW'(W_INIT);
      applied_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.upd_valid) begin
        prob_q <= bus.prob;
        inc_q  <= bus.inc;
      end
      if (state_q == DRAW) begin
        applied_q <= step_en;
        if (step_en) weight_q <= inc_q ? weight_q + 1'b1 : weight_q - 1'b1;
      end
    end
  end

  assign bus.weight  = weight_q;
  assign bus.applied = bus.upd_done & applied_q;

`ifdef SWU_DROP_CNT_EN
  logic drop_ev;
  assign drop_ev = bus.upd_valid && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst)                             drop_cnt <= '0;
    else if (drop_ev && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule
